// File: rtl/s8sp_pkg.sv
// Shared definitions for the memory access controller: FSM encoding and
// the default wait-state budget.
package s8sp_pkg;

  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    WR_WAIT  = 3'd2,
    COMPLETE = 3'd3,
    ERROR    = 3'd4
  } mac_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// 4-bit wait-state counter; expired flags the last cycle a strobe may wait
// before the transaction is abandoned.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [3:0] LAST = 4'(TIMEOUT - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if (clear) begin
      cnt <= 4'd0;
    end else if (count_en) begin
      cnt <= cnt + 4'd1;
    end
  end

  // cnt already holds TIMEOUT-1 missed cycles, so this cycle is the TIMEOUT-th.
  assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: single outstanding read or write towards a
// handshaked memory, with wait-state timeout and data-register load.
module mem_access_ctrl
  import s8sp_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_rd,
  input  logic       req_wr,
  input  logic [7:0] addr_in,
  input  logic [7:0] wdata_in,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_rd,
  output logic       mem_wr,
  input  logic       mem_ready,
  input  logic [7:0] mem_rdata,
  output logic [7:0] data_on_dr,
  output logic       load_dr,
  output logic       busy,
  output logic       done,
  output logic       timeout_err
);

  mac_state_t state;
  logic       in_wait;
  logic       accept;
  logic       expired;

  assign in_wait = (state == RD_WAIT) || (state == WR_WAIT);
  assign accept  = (state == IDLE) && (req_rd || req_wr);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .count_en (in_wait && !mem_ready),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mem_addr    <= 8'h00;
      mem_wdata   <= 8'h00;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      data_on_dr  <= 8'h00;
      load_dr     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done        <= 1'b0;
      load_dr     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mem_addr  <= addr_in;
            mem_wdata <= wdata_in;
            busy      <= 1'b1;
            // Read wins when both requests arrive together.
            if (req_rd) begin
              state  <= RD_WAIT;
              mem_rd <= 1'b1;
            end else begin
              state  <= WR_WAIT;
              mem_wr <= 1'b1;
            end
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (mem_ready) begin
            state   <= COMPLETE;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            done    <= 1'b1;
            if (state == RD_WAIT) begin
              data_on_dr <= mem_rdata;
              load_dr    <= 1'b1;
            end
          end else if (expired) begin
            state       <= ERROR;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        COMPLETE, ERROR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
